// File: rtl/k12a_seq_ctrl_if.sv
// Shared state encoding and the grouped decode/memory/control signals
// that connect the K12a sequencing controller to the core.
package k12a_seq_pkg;

    typedef enum logic [2:0] {
        STATE_FETCH1 = 3'd0,
        STATE_FETCH2 = 3'd1,
        STATE_FETCH3 = 3'd2,
        STATE_EXEC   = 3'd3,
        STATE_POP    = 3'd4,
        STATE_RJMP   = 3'd5,
        STATE_HALT   = 3'd6
    } state_t;

endpackage

// Memory handshake: a memory-accessing state is in flight while dec_mem_enable
// is high; the access completes on the first cycle where the wait counter has
// reached WAIT_STATES and mem_ready is high, which is exactly when commit rises.
interface k12a_seq_ctrl_if #(
    parameter int COUNT_WIDTH = 16
);
    import k12a_seq_pkg::*;

    state_t                 dec_next_state;
    logic                   dec_mem_enable;
    logic                   mem_ready;
    logic                   wake;
    state_t                 state;
    logic                   commit;
    logic                   stall;
    logic                   halted;
    logic [COUNT_WIDTH-1:0] inst_count;
    logic [3:0]             dbg_wait_cnt;
    logic                   dbg_wake_pending;

    modport master (
        output dec_next_state, dec_mem_enable, mem_ready, wake,
        input  state, commit, stall, halted, inst_count, dbg_wait_cnt, dbg_wake_pending
    );

    modport slave (
        input  dec_next_state, dec_mem_enable, mem_ready, wake,
        output state, commit, stall, halted, inst_count, dbg_wait_cnt, dbg_wake_pending
    );

endinterface

// File: rtl/k12a_seq_ctrl.sv
// Registered sequencing controller for the K12a core: state register, memory
// wait states, sticky wake capture for HALT and a retired-instruction counter.
module k12a_seq_ctrl
    import k12a_seq_pkg::*;
#(
    parameter int WAIT_STATES = 0,
    parameter int COUNT_WIDTH = 16
) (
    input logic            clock,
    input logic            reset,
    k12a_seq_ctrl_if.slave bus
);

    localparam int WW = (WAIT_STATES < 1) ? 1 : $clog2(WAIT_STATES + 1);
    localparam logic [WW-1:0] WAIT_MAX = WW'(WAIT_STATES);

    state_t                 state_q;
    logic [WW-1:0]          wait_cnt;
    logic                   wake_pending;
    logic [COUNT_WIDTH-1:0] count_q;

    logic in_halt;
    logic commit;
    logic wake_any;
    logic retire;

    assign in_halt  = (state_q == STATE_HALT);
    assign wake_any = bus.wake | wake_pending;

    // HALT always commits so the datapath never sees a stalled halt.
    assign commit = in_halt | ~bus.dec_mem_enable
                  | ((wait_cnt == WAIT_MAX) & bus.mem_ready);

    // Instructions retire on the return to FETCH1; a halt retires as it enters HALT.
    assign retire = commit & ~in_halt &
        ((((state_q == STATE_EXEC) | (state_q == STATE_POP) | (state_q == STATE_RJMP))
          & (bus.dec_next_state == STATE_FETCH1))
         | ((state_q == STATE_EXEC) & (bus.dec_next_state == STATE_HALT)));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= STATE_FETCH1;
            wait_cnt     <= '0;
            wake_pending <= 1'b0;
            count_q      <= '0;
        end else begin
            if (commit) begin
                wait_cnt <= '0;
                if (in_halt) begin
                    if (wake_any) begin
                        state_q <= STATE_FETCH1;
                    end
                end else begin
                    state_q <= bus.dec_next_state;
                end
            end else if (wait_cnt != WAIT_MAX) begin
                wait_cnt <= wait_cnt + WW'(1);
            end

            if (in_halt && wake_any) begin
                wake_pending <= 1'b0;
            end else if (bus.wake) begin
                wake_pending <= 1'b1;
            end

            if (retire) begin
                count_q <= count_q + COUNT_WIDTH'(1);
            end
        end
    end

    assign bus.state            = state_q;
    assign bus.commit           = commit;
    assign bus.stall            = ~commit;
    assign bus.halted           = in_halt;
    assign bus.inst_count       = count_q;
    assign bus.dbg_wait_cnt     = 4'(wait_cnt);
    assign bus.dbg_wake_pending = wake_pending;

endmodule
